// File: rtl/pixel_array_pkg.sv
// Shared types and helpers for the pixel array controller and its per-pixel capture cells.
package pixel_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READOUT
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_N_PIX = 4;

  // Full-scale code for a dw-bit ramp; an untripped pixel reports this value.
  function automatic logic [31:0] sat_code(input int dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_capture.sv
// One pixel's capture cell: latches the ramp code at the first comparator trip, then holds it.
module pixel_capture
  import pixel_array_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          convert_en,
  input  logic          cmp,
  input  logic          saturate,
  input  logic [DW-1:0] ramp_code,
  output logic [DW-1:0] code_nxt
);

  localparam logic [DW-1:0] SAT = DW'(sat_code(DW));

  logic [DW-1:0] code;
  logic          lock;
  logic          lock_nxt;

  // code_nxt is the value the code register takes at the coming edge, so the
  // readout can present a code captured in the very last conversion cycle.
  always_comb begin
    code_nxt = code;
    lock_nxt = lock;
    if (clear) begin
      code_nxt = '0;
      lock_nxt = 1'b0;
    end else if (convert_en && !lock && (cmp || saturate)) begin
      code_nxt = cmp ? ramp_code : SAT;
      lock_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code <= '0;
      lock <= 1'b0;
    end else begin
      code <= code_nxt;
      lock <= lock_nxt;
    end
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for an N_PIX single-slope pixel array: erase, expose, ramp convert, stream out.
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int N_PIX         = DEF_N_PIX,
  parameter int DW            = DEF_DW,
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [N_PIX-1:0]         cmp,
  output logic                     ERASE,
  output logic                     EXPOSE,
  output logic                     RAMP,
  output logic [DW-1:0]            ramp_code,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(N_PIX)-1:0] out_index,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int IW     = $clog2(N_PIX);
  localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);

  localparam logic [DW-1:0] RAMP_MAX    = DW'(sat_code(DW));
  localparam logic [PW-1:0] ERASE_LAST  = PW'(ERASE_CYCLES - 1);
  localparam logic [PW-1:0] EXPOSE_LAST = PW'(EXPOSE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_PIX - 1);

  state_t        state;
  logic [PW-1:0] phase;
  logic [DW-1:0] codes_nxt [N_PIX];
  logic          saturate;
  logic [IW-1:0] idx_nxt;

  // Pixels still unlocked in the final ramp step take full scale.
  assign saturate = RAMP && (ramp_code == RAMP_MAX);
  assign idx_nxt  = out_index + 1'b1;

  for (genvar g = 0; g < N_PIX; g++) begin : g_pix
    pixel_capture #(.DW(DW)) u_pix (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (ERASE),
      .convert_en (RAMP),
      .cmp        (cmp[g]),
      .saturate   (saturate),
      .ramp_code  (ramp_code),
      .code_nxt   (codes_nxt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      ramp_code  <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ERASE;
            ERASE <= 1'b1;
            busy  <= 1'b1;
            phase <= '0;
          end
        end
        ST_ERASE: begin
          if (phase == ERASE_LAST) begin
            state  <= ST_EXPOSE;
            ERASE  <= 1'b0;
            EXPOSE <= 1'b1;
            phase  <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (phase == EXPOSE_LAST) begin
            state     <= ST_CONVERT;
            EXPOSE    <= 1'b0;
            RAMP      <= 1'b1;
            ramp_code <= '0;
            phase     <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_CONVERT: begin
          // The counter stops at full scale; it never wraps into a second sweep.
          if (ramp_code == RAMP_MAX) begin
            state     <= ST_READOUT;
            RAMP      <= 1'b0;
            ramp_code <= '0;
            out_valid <= 1'b1;
            out_index <= '0;
            out_last  <= 1'b0;
            out_data  <= codes_nxt[0];
          end else begin
            ramp_code <= ramp_code + 1'b1;
          end
        end
        ST_READOUT: begin
          if (out_ready) begin
            if (out_last) begin
              state      <= ST_IDLE;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_index  <= '0;
              out_data   <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              out_index <= idx_nxt;
              out_data  <= codes_nxt[idx_nxt];
              out_last  <= (idx_nxt == IDX_LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

- Parametrised, clocked successor to the fixed four-pixel sensor array.
- Sequences one frame through erase, expose and ramp conversion, then streams the captured codes out.
- N_PIX pixel comparators are digitised against a shared DW-bit ramp counter; each pixel latches the counter value at its first comparator trip.
- The frame is read out pixel by pixel over a valid/ready stream. This replaces the shared tri-state DATA buses.

## Interface
Parameters:
- N_PIX, 4, number of pixels (≥2)
- DW, 8, code width; ramp runs codes 0..2^DW-1
- ERASE_CYCLES, 4, cycles ERASE is held high (≥1)
- EXPOSE_CYCLES, 255, cycles EXPOSE is held high (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- cmp  in  N_PIX  pixel comparator outputs, already synchronous to clk; high = ramp ≥ pixel voltage
- ERASE  out  1  pixel erase strobe
- EXPOSE  out  1  pixel exposure strobe
- RAMP  out  1  ramp/convert enable, high during CONVERT
- ramp_code  out  DW  current counter value driven to ramp DAC
- busy  out  1  high in every state except IDLE
- out_valid  out  1  readout data valid
- out_ready  in  1  downstream accept
- out_data  out  DW  captured code of pixel out_index
- out_index  out  $clog2(N_PIX)  pixel number
- out_last  out  1  high with the beat for pixel N_PIX-1
- frame_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → READOUT → IDLE.
- IDLE:
  - start=1 moves to ERASE next cycle.
  - start in any other state is ignored (no queuing).
- ERASE:
  - ERASE=1 for exactly ERASE_CYCLES cycles.
  - Clears all pixel codes to 0 and all lock bits.
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles.
- CONVERT:
  - RAMP=1; ramp_code counts 0,1,…,2^DW-1, one step per cycle, 2^DW cycles total.
  - Capture: in a cycle where cmp[i]=1 and pixel i is unlocked, pixel i stores the current ramp_code and locks.
  - Later cmp edges (including glitches back low) are ignored until the next ERASE.
  - All pixels tripping in the same cycle each store that same code.
  - Codes are not swept past 2^DW-1; the counter does not wrap.
  - A pixel still unlocked after code 2^DW-1 stores 2^DW-1 (saturated dark pixel).
- READOUT:
  - Beats go out for out_index 0..N_PIX-1 in order, with out_data = code[out_index].
  - A beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_index and out_last are held stable.
  - out_valid never drops before its beat transfers.
  - After the last beat transfers: frame_done=1 for one cycle, state returns to IDLE.
- ramp_code is 0 outside CONVERT. ERASE, EXPOSE and RAMP are mutually exclusive.
- Reset (reset_n=0 on any edge, mid-frame included):
  - State → IDLE; pixel codes and locks cleared; ramp counter cleared.
  - Any in-progress frame is abandoned with no frame_done.

## Timing
- All outputs registered.
- Reset values: ERASE=0, EXPOSE=0, RAMP=0, ramp_code=0, busy=0, out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0.
- start=1 at edge t:
  - ERASE=1 and busy=1 from cycle t+1 through t+ERASE_CYCLES.
  - EXPOSE for the next EXPOSE_CYCLES cycles.
  - RAMP/CONVERT for the next 2^DW cycles.
- cmp[i] high in the cycle ramp_code=k stores code k, visible at readout.
- First out_valid appears the cycle after the last CONVERT cycle.
- With out_ready held 1, readout takes N_PIX cycles, one beat per cycle.
- frame_done pulses in the cycle after the last transfer; busy=0 in that same cycle.
- Total frame length with out_ready=1: 1 + ERASE_CYCLES + EXPOSE_CYCLES + 2^DW + N_PIX + 1 cycles from start to frame_done.
- start is accepted in the frame_done cycle (IDLE).

## Structure
- Package pixel_array_pkg holds:
  - state typedef enum (IDLE, ERASE, EXPOSE, CONVERT, READOUT);
  - localparams for default DW, N_PIX and the saturation code function.
- Sub-module pixel_capture, generated N_PIX times. Each instance holds:
  - a DW-bit code register and a lock bit;
  - inputs: clear, convert_en, cmp, ramp_code, saturate.
- pixel_array_ctrl holds the FSM, phase counter, ramp counter and readout mux.

## Test plan
- Defaults, cmp[i] tied to a (ramp_code ≥ {20, 100, 180, 255}) model → readout codes 20, 100, 180, 255; out_last on index 3; frame_done 1 + 4 + 255 + 256 + 4 + 1 cycles after start.
- cmp[2] never high → code 255. cmp[0] high from code 0 → 0. cmp[1] pulses at 50, low, then high at 90 → 50.
- out_ready toggled 1,0,0,1 pseudo-randomly → data and index stable while stalled, 4 beats in order, no drops or duplicates.
- start pulsed during EXPOSE and during READOUT → ignored; frame timing unchanged; next start in the frame_done cycle begins ERASE next cycle.
- reset_n=0 for one cycle mid-CONVERT → all outputs at reset values next cycle, no frame_done; a new frame reports fresh codes, none from the aborted frame.
- N_PIX=6, DW=4 → ramp 0..15, six beats, out_index 0..5, 3-bit out_index.
